// File: rtl/wb_soc_pkg.sv
// Shared SoC bus definitions: slave target ids, region map constants and the
// address decode used by the Wishbone interconnect.
package wb_soc_pkg;

  typedef enum logic [1:0] {
    TGT_ROM  = 2'd0,
    TGT_RAM  = 2'd1,
    TGT_IO   = 2'd2,
    TGT_NONE = 2'd3
  } tgt_e;

  localparam logic [31:0] ROM_BASE = 32'hb000_0000;
  localparam logic [31:0] ROM_MASK = 32'hffff_8000;
  localparam logic [31:0] RAM_BASE = 32'hb000_8000;
  localparam logic [31:0] RAM_MASK = 32'hffff_8000;
  localparam logic [31:0] IO_BASE  = 32'hc000_0000;
  localparam logic [31:0] IO_MASK  = 32'hf000_0000;

  function automatic tgt_e decode_tgt(input logic [31:0] addr);
    if ((addr & ROM_MASK) == ROM_BASE) return TGT_ROM;
    if ((addr & RAM_MASK) == RAM_BASE) return TGT_RAM;
    if ((addr & IO_MASK) == IO_BASE)   return TGT_IO;
    return TGT_NONE;
  endfunction

endpackage

// File: rtl/wb_bus_decoder_if.sv
// Core-side pipelined Wishbone bundle; the decoder sits on the slave modport.
interface wb_bus_decoder_if;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [31:0] i_wb_addr;
  logic [31:0] i_wb_data;
  logic [31:0] o_wb_data;
  logic        o_wb_stall;
  logic        o_wb_ack;
  logic        o_wb_err;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
    input  o_wb_data, o_wb_stall, o_wb_ack, o_wb_err
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
    output o_wb_data, o_wb_stall, o_wb_ack, o_wb_err
  );
endinterface

// File: rtl/wb_track_fifo.sv
// In-flight target tracker: DEPTH x 2-bit synchronous FIFO with flush,
// exposing the oldest (head) and newest (tail) entries.
module wb_track_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [1:0] wdata,
  output logic       full,
  output logic       empty,
  output logic [1:0] head,
  output logic [1:0] tail
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][1:0] mem_q, mem_d;
  logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rptr_q];
  assign tail    = mem_q[wptr_q - PTR_W'(1)];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = wdata;
        wptr_d        = wptr_q + PTR_W'(1);
      end
      if (do_pop) rptr_d = rptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/wb_bus_decoder.sv
// Pipelined Wishbone decoder: steers core beats to ROM/RAM/IO, returns acks in
// order, errors unmapped beats. WB_DECODER_TIMEOUT_EN adds an ack watchdog.
module wb_bus_decoder
  import wb_soc_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic            clk,
  input  logic            reset,
  wb_bus_decoder_if.slave wb,
  output logic            o_s_cyc,
  output logic            o_s_we,
  output logic [31:0]     o_s_addr,
  output logic [31:0]     o_s_data,
  output logic            o_rom_stb,
  output logic            o_ram_stb,
  output logic            o_io_stb,
  input  logic            i_rom_stall,
  input  logic            i_ram_stall,
  input  logic            i_io_stall,
  input  logic            i_rom_ack,
  input  logic            i_ram_ack,
  input  logic            i_io_ack,
  input  logic [31:0]     i_rom_data,
  input  logic [31:0]     i_ram_data,
  input  logic [31:0]     i_io_data
);
  logic        full, empty;
  logic [1:0]  head_raw, tail_raw;
  tgt_e        tgt, head, tail;
  logic        sel_stall, hold, req, accept, flush, wd_fire;
  logic        head_ack, pop, ack;
  logic [31:0] head_data;

  assign o_s_cyc  = wb.i_wb_cyc;
  assign o_s_we   = wb.i_wb_we;
  assign o_s_addr = wb.i_wb_addr;
  assign o_s_data = wb.i_wb_data;
  assign head     = tgt_e'(head_raw);
  assign tail     = tgt_e'(tail_raw);

  // Response side is kept apart from the request side so the watchdog can
  // depend on pop without forming a combinational block loop.
  always_comb begin
    head_ack  = 1'b0;
    head_data = '0;
    unique case (head)
      TGT_ROM: begin head_ack = i_rom_ack; head_data = i_rom_data; end
      TGT_RAM: begin head_ack = i_ram_ack; head_data = i_ram_data; end
      TGT_IO:  begin head_ack = i_io_ack;  head_data = i_io_data;  end
      default: begin head_ack = 1'b0;      head_data = '0;         end
    endcase
    ack          = wb.i_wb_cyc & ~empty & (head != TGT_NONE) & head_ack;
    pop          = wb.i_wb_cyc & ~empty & ((head == TGT_NONE) | head_ack);
    wb.o_wb_ack  = ack;
    wb.o_wb_data = ack ? head_data : '0;
  end

  always_comb begin
    tgt       = decode_tgt(wb.i_wb_addr);
    sel_stall = 1'b0;
    unique case (tgt)
      TGT_ROM: sel_stall = i_rom_stall;
      TGT_RAM: sel_stall = i_ram_stall;
      TGT_IO:  sel_stall = i_io_stall;
      default: sel_stall = 1'b0;
    endcase
    req           = wb.i_wb_cyc & wb.i_wb_stb;
    // A target switch waits for the FIFO to drain so responses stay ordered.
    hold          = full | (~empty & (tgt != tail)) | wd_fire;
    wb.o_wb_stall = hold | sel_stall;
    accept        = req & ~hold & ~sel_stall;
    o_rom_stb     = req & ~hold & (tgt == TGT_ROM);
    o_ram_stb     = req & ~hold & (tgt == TGT_RAM);
    o_io_stb      = req & ~hold & (tgt == TGT_IO);
    wb.o_wb_err   = (wb.i_wb_cyc & ~empty & (head == TGT_NONE)) | wd_fire;
    flush         = ~wb.i_wb_cyc | wd_fire;
  end

`ifdef WB_DECODER_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_q, wd_d;

  always_comb begin
    wd_fire = wb.i_wb_cyc & ~empty & ~pop & (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    wd_d    = (~wb.i_wb_cyc | empty | pop | wd_fire) ? '0 : wd_q + WD_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign wd_fire        = 1'b0;
`endif

  wb_track_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (accept),
    .pop   (pop),
    .flush (flush),
    .wdata (tgt),
    .full  (full),
    .empty (empty),
    .head  (head_raw),
    .tail  (tail_raw)
  );
endmodule

// File: tb/tb_wb_bus_decoder.sv
// Bench for wb_bus_decoder: directed scenarios with literal expectations, then
// randomized traffic against a queue-based reference of the bus rules.
module tb_wb_bus_decoder;
  localparam int DEPTH = 4;
  localparam int TMO   = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_bus_decoder_if bus ();
  logic [2:0]  s_stall, s_ack;
  logic [31:0] s_data [3];
  logic        o_s_cyc, o_s_we, rom_stb, ram_stb, io_stb;
  logic [31:0] o_s_addr, o_s_data;

  wb_bus_decoder #(
    .MAX_OUTSTANDING (DEPTH),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .wb          (bus),
    .o_s_cyc     (o_s_cyc),
    .o_s_we      (o_s_we),
    .o_s_addr    (o_s_addr),
    .o_s_data    (o_s_data),
    .o_rom_stb   (rom_stb),
    .o_ram_stb   (ram_stb),
    .o_io_stb    (io_stb),
    .i_rom_stall (s_stall[0]),
    .i_ram_stall (s_stall[1]),
    .i_io_stall  (s_stall[2]),
    .i_rom_ack   (s_ack[0]),
    .i_ram_ack   (s_ack[1]),
    .i_io_ack    (s_ack[2]),
    .i_rom_data  (s_data[0]),
    .i_ram_data  (s_data[1]),
    .i_io_data   (s_data[2])
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Region of an address from the memory map: 0 ROM, 1 RAM, 2 IO, 3 unmapped.
  function automatic int region(input logic [31:0] a);
    if (a >= 32'hb000_0000 && a <= 32'hb000_7fff) return 0;
    if (a >= 32'hb000_8000 && a <= 32'hb000_ffff) return 1;
    if (a >= 32'hc000_0000 && a <= 32'hcfff_ffff) return 2;
    return 3;
  endfunction

  // Reference: queue of outstanding targets, oldest first.
  int mq[$];
  int stuck = 0;

  initial begin
    int t, n, h, ssl;
    bit cyc, req, hack, pop, fire, hold, stall, acc, e_ack, e_err;
    logic [31:0] e_data;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        mq.delete();
        stuck = 0;
        chk("rst_ack", bus.o_wb_ack, 0);
        chk("rst_err", bus.o_wb_err, 0);
        chk("rst_stall", bus.o_wb_stall, 0);
        chk("rst_stb", {rom_stb, ram_stb, io_stb}, 0);
      end else begin
        cyc  = bus.i_wb_cyc;
        req  = cyc && bus.i_wb_stb;
        t    = region(bus.i_wb_addr);
        n    = mq.size();
        h    = (n > 0) ? mq[0] : 3;
        hack = (n > 0 && h < 3) ? s_ack[h] : 1'b0;
        pop  = cyc && n > 0 && (h == 3 || hack);
        fire = 1'b0;
`ifdef WB_DECODER_TIMEOUT_EN
        fire = cyc && n > 0 && !pop && stuck == TMO - 1;
`endif
        hold   = (n == DEPTH) || (n > 0 && t != mq[n-1]) || fire;
        ssl    = (t < 3) ? int'(s_stall[t]) : 0;
        stall  = hold || (ssl != 0);
        acc    = req && !stall;
        e_ack  = cyc && n > 0 && h < 3 && hack;
        e_err  = (cyc && n > 0 && h == 3) || fire;
        e_data = e_ack ? s_data[h] : 32'h0;
        chk("m_stall", bus.o_wb_stall, stall);
        chk("m_ack", bus.o_wb_ack, e_ack);
        chk("m_err", bus.o_wb_err, e_err);
        chk("m_data", bus.o_wb_data, e_data);
        chk("m_rom_stb", rom_stb, req && !hold && t == 0);
        chk("m_ram_stb", ram_stb, req && !hold && t == 1);
        chk("m_io_stb", io_stb, req && !hold && t == 2);
        chk("m_s_cyc", o_s_cyc, cyc);
        chk("m_s_we", o_s_we, bus.i_wb_we);
        chk("m_s_addr", o_s_addr, bus.i_wb_addr);
        chk("m_s_data", o_s_data, bus.i_wb_data);
        if (!cyc || fire) begin
          mq.delete();
        end else begin
          if (pop) void'(mq.pop_front());
          if (acc) mq.push_back(t);
        end
        if (!cyc || fire || pop || n == 0) stuck = 0;
        else stuck++;
      end
    end
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic look();
    #3;
  endtask

  task automatic drive(input bit c, input bit s, input bit w, input logic [31:0] a);
    bus.i_wb_cyc  = c;
    bus.i_wb_stb  = s;
    bus.i_wb_we   = w;
    bus.i_wb_addr = a;
    bus.i_wb_data = a ^ 32'h5a5a_5a5a;
  endtask

  task automatic idle();
    drive(0, 0, 0, 32'h0);
    s_stall   = '0;
    s_ack     = '0;
    s_data[0] = 32'h1111_1111;
    s_data[1] = 32'h2222_2222;
    s_data[2] = 32'h3333_3333;
  endtask

  int  pend [3][$];
  bit  prev_stall;
  int  early;

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (3) nxt();
    look();
    chk("reset_ack", bus.o_wb_ack, 0);
    chk("reset_stall", bus.o_wb_stall, 0);
    nxt();
    rst_n = 1'b1;

    // ROM read, ack with data one cycle later
    nxt(); drive(1, 1, 0, 32'hb000_0004); look();
    chk("t1_rom_stb", rom_stb, 1); chk("t1_ram_stb", ram_stb, 0); chk("t1_stall", bus.o_wb_stall, 0);
    nxt(); bus.i_wb_stb = 0; s_ack[0] = 1; s_data[0] = 32'h1234_5678; look();
    chk("t1_ack", bus.o_wb_ack, 1); chk("t1_data", bus.o_wb_data, 32'h1234_5678); chk("t1_ram_stb2", ram_stb, 0);
    nxt(); s_ack[0] = 0; look();
    chk("t1_ack_done", bus.o_wb_ack, 0);

    // four RAM writes fill the tracker, the fifth stalls, acks drain in order
    for (int i = 0; i < 4; i++) begin
      nxt(); drive(1, 1, 1, 32'hb000_8000 + 32'(4 * i)); look();
      chk("t2_ram_stb", ram_stb, 1);
    end
    nxt(); drive(1, 1, 1, 32'hb000_8010); look();
    chk("t2_full_stall", bus.o_wb_stall, 1); chk("t2_full_stb", ram_stb, 0);
    for (int i = 0; i < 4; i++) begin
      nxt(); bus.i_wb_stb = 0; s_ack[1] = 1; s_data[1] = 32'ha0 + 32'(i); look();
      chk("t2_ack", bus.o_wb_ack, 1); chk("t2_data", bus.o_wb_data, 32'ha0 + 32'(i));
    end
    nxt(); s_ack[1] = 0; drive(1, 1, 0, 32'hb000_0020); look();
    chk("t2_empty_rom_stb", rom_stb, 1); chk("t2_empty_stall", bus.o_wb_stall, 0);
    nxt(); bus.i_wb_stb = 0; s_ack[0] = 1; look();
    chk("t2_rom_ack", bus.o_wb_ack, 1);
    nxt(); s_ack[0] = 0;

    // ROM then RAM: RAM waits until the ROM ack pops
    drive(1, 1, 0, 32'hb000_0010); look();
    chk("t3_rom_stb", rom_stb, 1);
    nxt(); drive(1, 1, 0, 32'hb000_8010); look();
    chk("t3_ram_stall", bus.o_wb_stall, 1); chk("t3_ram_stb0", ram_stb, 0);
    nxt(); s_ack[0] = 1; s_data[0] = 32'h0000_c0c0; look();
    chk("t3_rom_ack", bus.o_wb_ack, 1); chk("t3_rom_data", bus.o_wb_data, 32'h0000_c0c0);
    chk("t3_still_stall", bus.o_wb_stall, 1);
    nxt(); s_ack[0] = 0; look();
    chk("t3_ram_stb1", ram_stb, 1); chk("t3_ram_go", bus.o_wb_stall, 0);
    nxt(); bus.i_wb_stb = 0; s_ack[1] = 1; s_data[1] = 32'h0000_d0d0; look();
    chk("t3_ram_ack", bus.o_wb_ack, 1); chk("t3_ram_data", bus.o_wb_data, 32'h0000_d0d0);
    nxt(); s_ack[1] = 0;

    // unmapped access: no strobe, error pulse one cycle later
    drive(1, 1, 0, 32'h0000_1000); look();
    chk("t4_no_stb", {rom_stb, ram_stb, io_stb}, 0); chk("t4_err0", bus.o_wb_err, 0);
    nxt(); bus.i_wb_stb = 0; look();
    chk("t4_err1", bus.o_wb_err, 1); chk("t4_ack", bus.o_wb_ack, 0); chk("t4_data", bus.o_wb_data, 0);
    nxt(); look();
    chk("t4_err_end", bus.o_wb_err, 0);

    // abort with two RAM beats outstanding; late acks must be dropped
    nxt(); drive(1, 1, 0, 32'hb000_8100); look();
    chk("t5_stb_a", ram_stb, 1);
    nxt(); drive(1, 1, 0, 32'hb000_8104); look();
    chk("t5_stb_b", ram_stb, 1);
    nxt(); drive(0, 0, 0, 32'h0); look();
    chk("t5_abort_ack", bus.o_wb_ack, 0);
    nxt(); drive(1, 1, 0, 32'hb000_0040); s_ack[1] = 1; look();
    chk("t5_late_ack", bus.o_wb_ack, 0); chk("t5_new_stb", rom_stb, 1); chk("t5_new_stall", bus.o_wb_stall, 0);
    nxt(); bus.i_wb_stb = 0; look();
    chk("t5_late_ack2", bus.o_wb_ack, 0);
    nxt(); s_ack[1] = 0; s_ack[0] = 1; s_data[0] = 32'h5555; look();
    chk("t5_rom_ack", bus.o_wb_ack, 1);
    nxt(); s_ack[0] = 0; bus.i_wb_cyc = 0;

`ifdef WB_DECODER_TIMEOUT_EN
    // IO never acks: watchdog error on cycle TMO after acceptance
    nxt(); drive(1, 1, 0, 32'hc000_0100); look();
    chk("t6_io_stb", io_stb, 1);
    early = 0;
    for (int k = 1; k < TMO; k++) begin
      nxt(); bus.i_wb_stb = 0; look();
      if (bus.o_wb_err) early++;
    end
    chk("t6_no_early_err", early, 0);
    nxt(); look();
    chk("t6_wd_err", bus.o_wb_err, 1);
    nxt(); s_ack[2] = 1; look();
    chk("t6_late_ack", bus.o_wb_ack, 0); chk("t6_err_end", bus.o_wb_err, 0);
    nxt(); s_ack[2] = 0; bus.i_wb_cyc = 0;
`endif

    // randomized traffic; slaves ack 1..4 cycles after accepting a beat
    prev_stall = 1'b0;
    for (int cy = 0; cy < 3000; cy++) begin
      nxt();
      for (int s = 0; s < 3; s++)
        if (s_ack[s] && pend[s].size() > 0) void'(pend[s].pop_front());
      if (!(bus.i_wb_cyc && bus.i_wb_stb && prev_stall)) begin
        bus.i_wb_cyc = ($urandom_range(0, 19) != 0);
        bus.i_wb_stb = ($urandom_range(0, 9) < 6);
        bus.i_wb_we  = $urandom_range(0, 1) == 1;
        bus.i_wb_data = $urandom;
        case ($urandom_range(0, 3))
          0: bus.i_wb_addr = 32'hb000_0000 | ($urandom & 32'h0000_7ffc);
          1: bus.i_wb_addr = 32'hb000_8000 | ($urandom & 32'h0000_7ffc);
          2: bus.i_wb_addr = 32'hc000_0000 | ($urandom & 32'h0fff_fffc);
          default:
            case ($urandom_range(0, 3))
              0: bus.i_wb_addr = 32'h0000_1000;
              1: bus.i_wb_addr = 32'hb001_0000;
              2: bus.i_wb_addr = 32'hbfff_fffc;
              default: bus.i_wb_addr = 32'hd000_0000;
            endcase
        endcase
      end
      for (int s = 0; s < 3; s++) begin
        s_stall[s] = ($urandom_range(0, 4) == 0);
        if (pend[s].size() > 0) s_ack[s] = (pend[s][0] <= cy);
        else s_ack[s] = ($urandom_range(0, 29) == 0);
        s_data[s] = $urandom;
      end
      #1;
      prev_stall = bus.o_wb_stall;
      if (rom_stb && !s_stall[0]) pend[0].push_back(cy + 1 + int'($urandom_range(0, 3)));
      if (ram_stb && !s_stall[1]) pend[1].push_back(cy + 1 + int'($urandom_range(0, 3)));
      if (io_stb && !s_stall[2]) pend[2].push_back(cy + 1 + int'($urandom_range(0, 3)));
    end

    nxt(); idle();
    repeat (3) nxt();
    #4;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL sim_time_limit: got expired expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "time limit");
  end
endmodule
